pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter RST_CYCLES, default 20: PLL reset pulse width in refclk cycles (1 us at 20 MHz).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 2000: consecutive cycles of lock required before release.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 200000: cycles allowed in WAIT_LOCK before a retry.
REQ-004 Parameter MAX_RETRIES, default 7: timeouts tolerated before FAIL (range 1..15).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 refclk  in  1  sole clock; all logic is rising-edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 pll_locked  in  1  PLL lock indication; asynchronous to refclk.
REQ-009 soft_reset  in  1  synchronous single-cycle request to re-initialise the PLL.
REQ-010 pll_rst  out  1  active-high reset driven to the PLL rst input.
REQ-011 sys_rst_n  out  1  active-low reset for logic clocked by the PLL outputs.
REQ-012 ready  out  1  high while the PLL is locked and released.
REQ-013 fail  out  1  high once retries are exhausted.
REQ-014 retry_cnt  out  4  timeouts since the last entry to RUN.
REQ-015 lock_lost_cnt  out  8  lock-loss events seen in RUN, saturating.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchronizer; only the synchronized value (lk_s) is used, so input-to-decision latency is 2 cycles.
REQ-017 The FSM SHALL have the states RESET_PLL, WAIT_LOCK, STABILIZE, RUN and FAIL, and all outputs SHALL be registered decodes of the state.
REQ-018 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timer cleared.
REQ-019 WAIT_LOCK: if lk_s=1, go to STABILIZE.
REQ-020 WAIT_LOCK: when the timer reaches LOCK_TIMEOUT_CYCLES-1, increment retry_cnt; if the new value equals MAX_RETRIES go to FAIL, otherwise go to RESET_PLL.
REQ-021 STABILIZE: lk_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
REQ-022 STABILIZE: any lk_s=0 -> WAIT_LOCK with the stability counter cleared; the timeout timer is not cleared.
REQ-023 RUN: sys_rst_n=1, ready=1, and retry_cnt clears on entry.
REQ-024 RUN: lk_s=0 -> lock_lost_cnt increments (holding at 255) and the FSM goes to RESET_PLL; sys_rst_n=0 the next cycle.
REQ-025 FAIL: fail=1, pll_rst=0, sys_rst_n=0; the only exit is soft_reset.
REQ-026 soft_reset=1 in any state -> RESET_PLL with retry_cnt cleared, taking priority over every other transition; lock_lost_cnt is kept.
REQ-027 In every state other than RUN, sys_rst_n=0 and ready=0.
REQ-028 Counters SHALL be sized with $clog2 of their parameter and SHALL never wrap.

Reset
REQ-029 While rst_n=0, the state SHALL be RESET_PLL with pll_rst=1, sys_rst_n=0, ready=0, fail=0, and all counters and synchronizer flops at 0.
REQ-030 On rst_n deassertion, a full RST_CYCLES pulse SHALL begin; reset asserted mid-operation aborts immediately to these values.

Configuration
REQ-031 Macro PLL_MON_LOSS_CNT_EN defined: lock_lost_cnt SHALL be implemented per REQ-024.
REQ-032 Macro PLL_MON_LOSS_CNT_EN undefined: lock_lost_cnt SHALL be tied to 0 and no counter flops shall exist; all other behaviour is unchanged.

Structure
REQ-033 Package pll_mon_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset).

Verification (bench params: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=3)
REQ-035 Release rst_n, raise pll_locked at cycle 10 and hold it -> pll_rst high for cycles 0-3; sys_rst_n and ready rise 8 cycles after lk_s=1.
REQ-036 Keep pll_locked=0 -> 3 pulses of pll_rst, each 4 cycles, 32 cycles apart; retry_cnt=3, fail=1, pll_rst stays 0.
REQ-037 During STABILIZE, drop pll_locked for 1 cycle at stable count 5 -> no RUN until 8 fresh consecutive locked cycles.
REQ-038 In RUN, drop pll_locked -> sys_rst_n=0 3 cycles later, lock_lost_cnt=1, a 4-cycle pll_rst pulse follows; repeat 300 times -> lock_lost_cnt=255.
REQ-039 In FAIL, pulse soft_reset -> RESET_PLL, retry_cnt=0, fail=0; soft_reset and timeout in the same cycle -> RESET_PLL with retry_cnt=0.
REQ-040 Assert rst_n mid-STABILIZE -> outputs match REQ-029 at once; compiled without the macro, lock_lost_cnt stays 0 throughout REQ-038.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and default constants for the PLL lock monitor.
package pll_mon_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES          = 20;
    localparam int DEF_LOCK_STABLE_CYCLES  = 2000;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 200000;
    localparam int DEF_MAX_RETRIES         = 7;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, async active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input into the i_clk domain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL reset sequencer and lock monitor: pulses the PLL reset, qualifies lock, releases
// downstream reset, retries on timeout. Optional lock-loss counter: PLL_MON_LOSS_CNT_EN.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int RST_CYCLES          = DEF_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt
);

    localparam int RST_W = cnt_width(RST_CYCLES);
    localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);
    localparam bit               STB_ONE   = (LOCK_STABLE_CYCLES <= 1);

    pll_state_e       r_state;
    pll_state_e       w_next;
    logic [RST_W-1:0] r_rst_cnt;
    logic [RST_W-1:0] w_rst_cnt_nxt;
    logic [STB_W-1:0] r_stab;
    logic [STB_W-1:0] w_stab_nxt;
    logic [TMO_W-1:0] r_timer;
    logic [TMO_W-1:0] w_timer_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;
    logic             w_loss_evt;
    logic             w_lk_s;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;
    logic             r_fail;

    sync_2ff u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lk_s)
    );

    // Next-state and counter update; soft_reset overrides every state transition
    always_comb begin
        w_next        = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_stab_nxt    = r_stab;
        w_timer_nxt   = r_timer;
        w_retry_nxt   = r_retry;
        w_loss_evt    = 1'b0;
        if (soft_reset) begin
            w_next        = ST_RESET_PLL;
            w_rst_cnt_nxt = '0;
            w_stab_nxt    = '0;
            w_timer_nxt   = '0;
            w_retry_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_rst_cnt == RST_LAST) begin
                        w_next        = ST_WAIT_LOCK;
                        w_rst_cnt_nxt = '0;
                        w_timer_nxt   = '0;
                        w_stab_nxt    = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // The cycle that first sees lock already counts toward stability
                    if (w_lk_s) begin
                        if (STB_ONE) begin
                            w_next      = ST_RUN;
                            w_retry_nxt = 4'd0;
                        end else begin
                            w_next     = ST_STABILIZE;
                            w_stab_nxt = STB_W'(1);
                        end
                    end else if (r_timer == TMO_LAST) begin
                        w_retry_nxt   = r_retry + 4'd1;
                        w_rst_cnt_nxt = '0;
                        w_next        = (w_retry_nxt == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                    end else begin
                        w_timer_nxt = r_timer + TMO_W'(1);
                    end
                end
                ST_STABILIZE: begin
                    if (!w_lk_s) begin
                        w_next     = ST_WAIT_LOCK;
                        w_stab_nxt = '0;
                    end else if (r_stab == STB_LAST) begin
                        w_next      = ST_RUN;
                        w_stab_nxt  = '0;
                        w_retry_nxt = 4'd0;
                    end else begin
                        w_stab_nxt = r_stab + STB_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lk_s) begin
                        w_next        = ST_RESET_PLL;
                        w_rst_cnt_nxt = '0;
                        w_loss_evt    = 1'b1;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    w_next = ST_FAIL;
                end
                default: begin
                    w_next        = ST_RESET_PLL;
                    w_rst_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESET_PLL;
            r_rst_cnt <= '0;
            r_stab    <= '0;
            r_timer   <= '0;
            r_retry   <= 4'd0;
        end else begin
            r_state   <= w_next;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_stab    <= w_stab_nxt;
            r_timer   <= w_timer_nxt;
            r_retry   <= w_retry_nxt;
        end
    end

    // Outputs are registered decodes of the next state so they change with the state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_pll_rst   <= (w_next == ST_RESET_PLL);
            r_sys_rst_n <= (w_next == ST_RUN);
            r_ready     <= (w_next == ST_RUN);
            r_fail      <= (w_next == ST_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;

`ifdef PLL_MON_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Saturating count of lock losses seen while running; survives soft_reset
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end else begin
            r_loss_cnt <= r_loss_cnt;
        end
    end

    assign lock_lost_cnt = r_loss_cnt;
`else
    logic w_unused_loss_evt;
    assign w_unused_loss_evt = w_loss_evt;
    assign lock_lost_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed scenarios plus random lock traffic,
// all compared against a phase-level reference model.
module tb_pll_lock_monitor;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 3;

`ifdef PLL_MON_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;
    logic [15:0] obs_vec;

    int checks = 0;
    int errors = 0;

    pll_lock_monitor #(
        .RST_CYCLES          (RC),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (LT),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_reset    (soft_reset),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    assign obs_vec = {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_lost_cnt};

    // Reference model: a reset pulse phase, one merged "acquire" phase, run, and fail.
    typedef enum int {PH_PULSE, PH_ACQUIRE, PH_RUN, PH_FAIL} phase_e;
    phase_e m_ph;
    int     m_pulse_left;
    int     m_run_len;
    int     m_misses;
    int     m_retries;
    int     m_losses;
    logic   m_seen[$];

    task automatic model_reset();
        m_ph         = PH_PULSE;
        m_pulse_left = RC;
        m_run_len    = 0;
        m_misses     = 0;
        m_retries    = 0;
        m_losses     = 0;
        m_seen       = '{1'b0, 1'b0};
    endtask

    task automatic model_step();
        logic lk;
        lk = m_seen.pop_front();
        m_seen.push_back(pll_locked);
        if (soft_reset) begin
            m_ph         = PH_PULSE;
            m_pulse_left = RC;
            m_retries    = 0;
        end else begin
            case (m_ph)
                PH_PULSE: begin
                    m_pulse_left--;
                    if (m_pulse_left == 0) begin
                        m_ph      = PH_ACQUIRE;
                        m_run_len = 0;
                        m_misses  = 0;
                    end
                end
                PH_ACQUIRE: begin
                    if (lk) begin
                        m_run_len++;
                        if (m_run_len == LS) begin
                            m_ph      = PH_RUN;
                            m_retries = 0;
                        end
                    end else if (m_run_len > 0) begin
                        m_run_len = 0;
                    end else begin
                        m_misses++;
                        if (m_misses == LT) begin
                            m_retries++;
                            if (m_retries == MR) m_ph = PH_FAIL;
                            else begin
                                m_ph         = PH_PULSE;
                                m_pulse_left = RC;
                            end
                        end
                    end
                end
                PH_RUN: begin
                    if (!lk) begin
                        if (m_losses < 255) m_losses++;
                        m_ph         = PH_PULSE;
                        m_pulse_left = RC;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] model_vec();
        return {m_ph == PH_PULSE, m_ph == PH_RUN, m_ph == PH_RUN, m_ph == PH_FAIL,
                4'(m_retries), LOSS_EN ? 8'(m_losses) : 8'd0};
    endfunction

    task automatic tick(input logic lk, input logic sr);
        pll_locked = lk;
        soft_reset = sr;
        @(posedge refclk);
        if (rst_n) model_step();
        @(negedge refclk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] rst_vec;
        rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        @(negedge refclk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec !== rst_vec) begin
            errors++;
            $display("FAIL reset_async got=%h expected=%h", obs_vec, rst_vec);
        end
        for (int c = 0; c < 4; c++) begin
            tick(c[0], 1'b0);
            checks++;
            if (obs_vec !== rst_vec) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h expected=%h", c, obs_vec, rst_vec);
            end
        end
    endtask

    task automatic test_lock_acquire();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL acquire_model cyc=%0d got=%h expected=%h", c, obs_vec, model_vec());
            end
            checks++;
            if ({pll_rst, sys_rst_n, ready} !== {c < RC, c >= 10 + 2 + LS, c >= 10 + 2 + LS}) begin
                errors++;
                $display("FAIL acquire_timing cyc=%0d rst/srn/rdy=%b%b%b expected=%b%b%b", c,
                         pll_rst, sys_rst_n, ready, c < RC, c >= 10 + 2 + LS, c >= 10 + 2 + LS);
            end
            tick(c >= 10, 1'b0);
        end
    endtask

    task automatic test_timeout_fail();
        int per;
        logic exp_prst;
        logic [3:0] exp_retry;
        per = RC + LT;
        apply_reset();
        for (int c = 0; c < 130; c++) begin
            exp_prst  = (c < MR * per) && ((c % per) < RC);
            exp_retry = (c < MR * per) ? 4'(c / per) : 4'(MR);
            checks++;
            if (obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL timeout_model cyc=%0d got=%h expected=%h", c, obs_vec, model_vec());
            end
            checks++;
            if ({pll_rst, fail, retry_cnt} !== {exp_prst, c >= MR * per, exp_retry}) begin
                errors++;
                $display("FAIL timeout_seq cyc=%0d rst=%b fail=%b retry=%0d expected rst=%b fail=%b retry=%0d",
                         c, pll_rst, fail, retry_cnt, exp_prst, c >= MR * per, exp_retry);
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL glitch_model cyc=%0d got=%h expected=%h", c, obs_vec, model_vec());
            end
            checks++;
            if (ready !== (c >= 18)) begin
                errors++;
                $display("FAIL glitch_ready cyc=%0d ready=%b expected=%b", c, ready, c >= 18);
            end
            tick(c != 7, 1'b0);
        end
    endtask

    task automatic test_lock_loss();
        int w;
        int exp_loss;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            w = 0;
            while (ready !== 1'b1 && w < 40) begin
                checks++;
                if (obs_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL loss_relock_model iter=%0d got=%h expected=%h", i, obs_vec, model_vec());
                end
                tick(1'b1, 1'b0);
                w++;
            end
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL loss_relock iter=%0d ready=%b expected=1 within 40 cycles", i, ready);
                break;
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL loss_model iter=%0d k=%0d got=%h expected=%h", i, k, obs_vec, model_vec());
                end
                checks++;
                if ({sys_rst_n, pll_rst} !== {k < 3, (k >= 3) && (k < 3 + RC)}) begin
                    errors++;
                    $display("FAIL loss_seq iter=%0d k=%0d srn/rst=%b%b expected=%b%b", i, k,
                             sys_rst_n, pll_rst, k < 3, (k >= 3) && (k < 3 + RC));
                end
                tick(k != 0, 1'b0);
            end
            exp_loss = LOSS_EN ? ((i + 1 > 255) ? 255 : i + 1) : 0;
            checks++;
            if (lock_lost_cnt !== 8'(exp_loss)) begin
                errors++;
                $display("FAIL loss_count iter=%0d got=%0d expected=%0d", i, lock_lost_cnt, exp_loss);
            end
        end
        checks++;
        if (lock_lost_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin
            errors++;
            $display("FAIL loss_saturate got=%0d expected=%0d", lock_lost_cnt, LOSS_EN ? 255 : 0);
        end
    endtask

    task automatic test_soft_reset();
        apply_reset();
        for (int c = 0; c < 110; c++) tick(1'b0, 1'b0);
        checks++;
        if ({fail, pll_rst, retry_cnt} !== {1'b1, 1'b0, 4'(MR)}) begin
            errors++;
            $display("FAIL soft_pre fail=%b rst=%b retry=%0d expected fail=1 rst=0 retry=%0d",
                     fail, pll_rst, retry_cnt, MR);
        end
        for (int c = 0; c < 80; c++) begin
            checks++;
            if (obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL soft_model cyc=%0d got=%h expected=%h", c, obs_vec, model_vec());
            end
            if (c == 1 || c == 73) begin
                checks++;
                if ({pll_rst, fail, retry_cnt} !== {1'b1, 1'b0, 4'd0}) begin
                    errors++;
                    $display("FAIL soft_exit cyc=%0d rst=%b fail=%b retry=%0d expected rst=1 fail=0 retry=0",
                             c, pll_rst, fail, retry_cnt);
                end
            end
            if (c == 72) begin
                checks++;
                if (retry_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL soft_pre_timeout retry=%0d expected=1", retry_cnt);
                end
            end
            tick(1'b0, (c == 0) || (c == 72));
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] rst_vec;
        rst_vec = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
        apply_reset();
        for (int c = 0; c < 20; c++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int c = 0; c < 9; c++) tick(1'b1, 1'b0);
        checks++;
        if ((obs_vec !== model_vec()) || (pll_rst !== 1'b0) || (ready !== 1'b0)) begin
            errors++;
            $display("FAIL async_pre got=%h expected=%h", obs_vec, model_vec());
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec !== rst_vec) begin
            errors++;
            $display("FAIL async_mid_stab got=%h expected=%h", obs_vec, rst_vec);
        end
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int   seg;
        logic lvl;
        logic sr;
        seg = 0;
        lvl = 1'b0;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            if (seg == 0) begin
                lvl = ($urandom_range(0, 3) != 0);
                seg = $urandom_range(1, 50);
            end
            seg--;
            sr = ($urandom_range(0, 127) == 0);
            checks++;
            if (obs_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h expected=%h", c, obs_vec, model_vec());
            end
            tick(lvl, sr);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_timeout_fail();
        test_glitch();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog elapsed=%0t limit=%0t", $time, 1000000);
        $fatal(1, "simulation time limit reached");
    end

endmodule
